// File: rtl/execute_muldiv.sv
// execute_muldiv: EX stage with ALU/shifter and an iterative
// radix-2 multiply/divide unit that owns the HI/LO registers.
module execute_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int RW    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_ex_valid,
  input  logic [WIDTH-1:0] id_ex_rega,
  input  logic [WIDTH-1:0] id_ex_regb,
  input  logic [WIDTH-1:0] id_ex_imedext,
  input  logic             id_ex_selimregb,
  input  logic [2:0]       id_ex_aluop,
  input  logic             id_ex_unsig,
  input  logic [2:0]       id_ex_mdop,
  input  logic [RW-1:0]    id_ex_regdest,
  input  logic             id_ex_writereg,
  input  logic             id_ex_writeov,
  input  logic             mem_stall,
  output logic             ex_id_stall,
  output logic [WIDTH-1:0] ex_fw_wbvalue,
  output logic             ex_fw_writereg,
  output logic             ex_mem_valid,
  output logic [WIDTH-1:0] ex_mem_result,
  output logic [RW-1:0]    ex_mem_regdest,
  output logic             ex_mem_writereg,
  output logic             ex_mem_ov,
  output logic             md_busy
);

  localparam int CW = SHW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   ma;
  logic [WIDTH-1:0]   mb;
  logic               sa;
  logic               sb;
  logic               op_div;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  logic [WIDTH-1:0]   opb;
  logic [WIDTH:0]     add_x;
  logic [WIDTH:0]     sub_x;
  logic               lt;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   result;
  logic               ov;
  logic               wr_eff;

  logic is_mult;
  logic is_div;
  logic is_mfhi;
  logic is_mflo;
  logic is_mthi;
  logic is_mtlo;
  logic no_gpr;
  logic start;

  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  logic [WIDTH-1:0]   mul_add;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     r_sh;
  logic [WIDTH:0]     r_sub;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_nx;
  logic [2*WIDTH-1:0] div_next;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign opb   = id_ex_selimregb ? id_ex_imedext : id_ex_regb;
  assign add_x = {id_ex_rega[WIDTH-1], id_ex_rega}
               + {opb[WIDTH-1], opb};
  assign sub_x = {id_ex_rega[WIDTH-1], id_ex_rega}
               - {opb[WIDTH-1], opb};
  assign lt    = id_ex_unsig
               ? (id_ex_rega < opb)
               : ($signed(id_ex_rega) < $signed(opb));

  assign is_mult = (id_ex_mdop == 3'd1);
  assign is_div  = (id_ex_mdop == 3'd2);
  assign is_mfhi = (id_ex_mdop == 3'd3);
  assign is_mflo = (id_ex_mdop == 3'd4);
  assign is_mthi = (id_ex_mdop == 3'd5);
  assign is_mtlo = (id_ex_mdop == 3'd6);
  assign no_gpr  = is_mult | is_div | is_mthi | is_mtlo;

  assign md_busy     = (state != IDLE);
  assign ex_id_stall = mem_stall
                     | (md_busy & id_ex_valid & (id_ex_mdop != 3'd0));
  assign start       = id_ex_valid & (is_mult | is_div) & ~ex_id_stall;

  // ALU and shifter
  always_comb begin
    alu_res = '0;
    case (id_ex_aluop)
      3'd0:    alu_res = add_x[WIDTH-1:0];
      3'd1:    alu_res = sub_x[WIDTH-1:0];
      3'd2:    alu_res = id_ex_rega & opb;
      3'd3:    alu_res = id_ex_rega | opb;
      3'd4:    alu_res = id_ex_rega ^ opb;
      3'd5:    alu_res = ~(id_ex_rega | opb);
      3'd6:    alu_res = {{(WIDTH-1){1'b0}}, lt};
      3'd7:    alu_res = id_ex_rega << id_ex_regb[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

  // signed overflow only matters for add/sub
  always_comb begin
    ov = 1'b0;
    if (!id_ex_unsig) begin
      if (id_ex_aluop == 3'd0)
        ov = add_x[WIDTH] ^ add_x[WIDTH-1];
      else if (id_ex_aluop == 3'd1)
        ov = sub_x[WIDTH] ^ sub_x[WIDTH-1];
    end
  end

  // result select: HI/LO moves or ALU output
  always_comb begin
    result = alu_res;
    unique case (1'b1)
      is_mfhi: result = hi;
      is_mflo: result = lo;
      default: result = alu_res;
    endcase
  end

  assign wr_eff = id_ex_valid & id_ex_writereg & ~no_gpr
                & (~ov | id_ex_writeov);

  assign ex_fw_wbvalue  = ex_id_stall ? '0 : result;
  assign ex_fw_writereg = ~ex_id_stall & wr_eff;

  assign neg_a = ~id_ex_unsig & id_ex_rega[WIDTH-1];
  assign neg_b = ~id_ex_unsig & id_ex_regb[WIDTH-1];
  assign abs_a = neg_a ? -id_ex_rega : id_ex_rega;
  assign abs_b = neg_b ? -id_ex_regb : id_ex_regb;

  // shift-add: multiplier sits in the low half and drains right
  assign mul_add  = acc[0] ? ma : {WIDTH{1'b0}};
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // restoring divide: borrow out of the trial subtract picks the bit
  assign r_sh     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign r_sub    = r_sh - {1'b0, mb};
  assign q_bit    = ~r_sub[WIDTH];
  assign rem_nx   = q_bit ? r_sub[WIDTH-1:0] : r_sh[WIDTH-1:0];
  assign div_next = {rem_nx, acc[WIDTH-2:0], q_bit};

  assign prod   = (sa ^ sb) ? -acc : acc;
  assign quo    = acc[WIDTH-1:0];
  assign rem    = acc[2*WIDTH-1:WIDTH];
  assign fix_lo = !op_div       ? prod[WIDTH-1:0]
                : (mb == '0)    ? {WIDTH{1'b1}}
                : (sa ^ sb)     ? -quo
                :                 quo;
  assign fix_hi = !op_div ? prod[2*WIDTH-1:WIDTH]
                : sa      ? -rem
                :           rem;

  // multiply/divide sequencer and HI/LO
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      ma     <= '0;
      mb     <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      op_div <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            cnt    <= '0;
            ma     <= abs_a;
            mb     <= abs_b;
            sa     <= neg_a;
            sb     <= neg_b;
            op_div <= is_div;
            acc    <= {{WIDTH{1'b0}}, is_div ? abs_a : abs_b};
          end else if (id_ex_valid && !ex_id_stall) begin
            if (is_mthi) hi <= id_ex_rega;
            if (is_mtlo) lo <= id_ex_rega;
          end
        end
        RUN: begin
          acc <= op_div ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1))
            state <= FIX;
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_mem_valid    <= 1'b0;
      ex_mem_result   <= '0;
      ex_mem_regdest  <= '0;
      ex_mem_writereg <= 1'b0;
      ex_mem_ov       <= 1'b0;
    end else if (!mem_stall) begin
      ex_mem_valid    <= id_ex_valid & ~ex_id_stall;
      ex_mem_result   <= ex_fw_wbvalue;
      ex_mem_regdest  <= ex_id_stall ? '0 : id_ex_regdest;
      ex_mem_writereg <= ex_fw_writereg;
      ex_mem_ov       <= ov & ~ex_id_stall;
    end
  end

endmodule
